// File: rtl/lsu_mem_arbiter.sv
// Arbitrates the LSU data SRAM between the core load/store port and a word-only
// debug/preload port; each access runs IDLE -> ISSUE -> RESP with lane steering.
module lsu_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic              core_uns_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    output logic              core_err_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   starve_cnt;
    logic               sel_dbg;
    logic               lat_we;
    logic               lat_err;
    logic               lat_uns;
    logic [2:0]         lat_size;
    logic [1:0]         lat_off;

    logic               any_req;
    logic               dbg_win;
    logic               w_we;
    logic               w_uns;
    logic               w_err;
    logic [2:0]         w_size;
    logic [ADDR_W-1:0]  w_addr;
    logic [31:0]        w_wdata;

    function automatic logic size_illegal(input logic [2:0] sz, input logic [1:0] off);
        case (sz)
            3'b001:  return off != 2'b00;
            3'b010:  return off[0];
            3'b100:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] sz, input logic [1:0] off);
        case (sz)
            3'b001:  return 4'b1111;
            3'b010:  return 4'b0011 << {off[1], 1'b0};
            3'b100:  return 4'b0001 << off;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] sz, input logic [31:0] wd);
        case (sz)
            3'b010:  return {2{wd[15:0]}};
            3'b100:  return {4{wd[7:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] sz,
                                                input logic [1:0] off, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            3'b100:  return uns ? {24'b0, b} : 32'($signed(b));
            3'b010:  return uns ? {16'b0, h} : 32'($signed(h));
            default: return word;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

    assign any_req = core_req_i | dbg_req_i;
    assign dbg_win = dbg_req_i & (~core_req_i | (starve_cnt == CNT_MAX));

    // Debug traffic is forced to an aligned word so it can never fault.
    always_comb begin
        w_we    = core_we_i;
        w_uns   = core_uns_i;
        w_size  = core_size_i;
        w_addr  = core_addr_i;
        w_wdata = core_wdata_i;
        w_err   = size_illegal(core_size_i, core_addr_i[1:0]);
        if (dbg_win) begin
            w_we    = dbg_we_i;
            w_uns   = 1'b0;
            w_size  = 3'b001;
            w_addr  = dbg_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
            w_wdata = dbg_wdata_i;
            w_err   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            sel_dbg       <= 1'b0;
            lat_we        <= 1'b0;
            lat_err       <= 1'b0;
            core_gnt_o    <= 1'b0;
            dbg_gnt_o     <= 1'b0;
            core_rvalid_o <= 1'b0;
            dbg_rvalid_o  <= 1'b0;
            core_err_o    <= 1'b0;
            mem_en_o      <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_be_o      <= '0;
            mem_wdata_o   <= '0;
        end else begin
            core_gnt_o    <= 1'b0;
            dbg_gnt_o     <= 1'b0;
            core_rvalid_o <= 1'b0;
            dbg_rvalid_o  <= 1'b0;
            core_err_o    <= 1'b0;
            mem_en_o      <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_be_o      <= '0;
            mem_wdata_o   <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= ISSUE;
                        sel_dbg     <= dbg_win;
                        lat_we      <= w_we;
                        lat_err     <= w_err;
                        core_gnt_o  <= ~dbg_win;
                        dbg_gnt_o   <= dbg_win;
                        mem_en_o    <= ~w_err;
                        mem_we_o    <= w_we & ~w_err;
                        mem_addr_o  <= w_addr[ADDR_W-1:2];
                        mem_be_o    <= w_err ? 4'b0000 : lane_be(w_size, w_addr[1:0]);
                        mem_wdata_o <= lane_wdata(w_size, w_wdata);
                        if (dbg_win)
                            starve_cnt <= '0;
                        else if (dbg_req_i)
                            starve_cnt <= sat_inc(starve_cnt);
                    end
                end
                ISSUE: begin
                    state         <= RESP;
                    core_rvalid_o <= ~sel_dbg;
                    dbg_rvalid_o  <= sel_dbg;
                    core_err_o    <= ~sel_dbg & lat_err;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Load formatting fields only matter while rvalid is high, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && any_req) begin
            lat_uns  <= w_uns;
            lat_size <= w_size;
            lat_off  <= w_addr[1:0];
        end
    end

    // SRAM read data lands in RESP, so load data is steered combinationally from it.
    assign core_rdata_o = (core_rvalid_o && !lat_we && !core_err_o)
                          ? load_extend(mem_rdata_i, lat_size, lat_off, lat_uns) : 32'b0;
    assign dbg_rdata_o  = (dbg_rvalid_o && !lat_we) ? mem_rdata_i : 32'b0;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter with a byte-enabled SRAM model behind it.
module tb_lsu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_uns;
    logic [2:0]  core_size;
    logic [11:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] sram [0:1023];

    int          checks = 0;
    int          failures = 0;
    logic        r_en, r_we, r_err;
    logic [9:0]  r_ma;
    logic [3:0]  r_be;
    logic [31:0] r_wd, r_rd;
    int          r_lat;
    logic [9:0]  r_seq;

    lsu_mem_arbiter #(.ADDR_W(12), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_we_i(core_we), .core_uns_i(core_uns),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .core_err_o(core_err),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic d, input logic we, input logic uns, input logic [2:0] sz,
                       input logic [11:0] a, input logic [31:0] wd);
        int   n;
        logic seen;
        r_en = 1'b0; r_rd = '0; r_err = 1'b0; r_lat = 0;
        if (d) begin
            dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
        end else begin
            core_we = we; core_uns = uns; core_size = sz; core_addr = a;
            core_wdata = wd; core_req = 1'b1;
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            r_en |= mem_en;
            seen = d ? dbg_gnt : core_gnt;
        end
        r_ma = mem_addr; r_be = mem_be; r_wd = mem_wdata; r_we = mem_we;
        core_req = 1'b0; dbg_req = 1'b0;
        chk("gnt_seen", 32'(seen), 32'd1);
        r_lat = n; n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            r_en |= mem_en;
            seen = d ? dbg_rvalid : core_rvalid;
        end
        chk("rvalid_seen", 32'(seen), 32'd1);
        r_lat += n;
        r_rd  = d ? dbg_rdata : core_rdata;
        r_err = d ? 1'b0 : core_err;
        @(negedge clk);
        chk("rvalid_pulse", 32'(core_rvalid | dbg_rvalid), 32'd0);
    endtask

    task automatic grab(input int want);
        int n, got;
        r_seq = '0; got = 0; n = 0;
        while (got < want && n < 200) begin
            @(negedge clk); n++;
            if (core_gnt) begin r_seq = {r_seq[8:0], 1'b0}; got++; end
            if (dbg_gnt)  begin r_seq = {r_seq[8:0], 1'b1}; got++; end
        end
        chk("grab_count", got, want);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        mem_rdata = '0;
        rst = 1'b1;
        core_req = 0; core_we = 0; core_uns = 0; core_size = 3'b001; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {25'b0, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_err, mem_en, mem_we}, 32'd0);
        chk("rst_mem", {18'b0, mem_addr, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", core_rdata | dbg_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // word store / load
        txn(0, 1, 0, 3'b001, 12'h010, 32'hDEADBEEF);
        chk("sw_addr", 32'(r_ma), 32'h004);
        chk("sw_be", 32'(r_be), 32'hF);
        chk("sw_wdata", r_wd, 32'hDEADBEEF);
        chk("sw_we", 32'(r_we), 32'd1);
        chk("sw_rdata", r_rd, 32'd0);
        txn(0, 0, 0, 3'b001, 12'h010, 32'h0);
        chk("lw_rdata", r_rd, 32'hDEADBEEF);
        chk("lw_lat", r_lat, 32'd2);
        chk("lw_err", 32'(r_err), 32'd0);

        // byte and half lanes
        txn(0, 1, 0, 3'b100, 12'h013, 32'h000000A5);
        chk("sb_be", 32'(r_be), 32'h8);
        chk("sb_wdata", r_wd, 32'hA5A5A5A5);
        txn(0, 0, 0, 3'b100, 12'h013, 32'h0);
        chk("lb_rdata", r_rd, 32'hFFFFFFA5);
        txn(0, 0, 1, 3'b100, 12'h013, 32'h0);
        chk("lbu_rdata", r_rd, 32'h000000A5);
        txn(0, 0, 0, 3'b010, 12'h012, 32'h0);
        chk("lh_rdata", r_rd, 32'hFFFFA5AD);
        txn(0, 0, 1, 3'b010, 12'h010, 32'h0);
        chk("lhu_rdata", r_rd, 32'h0000BEEF);
        txn(0, 1, 0, 3'b010, 12'h012, 32'h00001234);
        chk("sh_be", 32'(r_be), 32'hC);
        chk("sh_wdata", r_wd, 32'h12341234);
        txn(0, 0, 0, 3'b001, 12'h010, 32'h0);
        chk("lw_after_sh", r_rd, 32'h1234BEEF);

        // illegal accesses
        txn(0, 1, 0, 3'b010, 12'h011, 32'hFFFFFFFF);
        chk("sh_mis_en", 32'(r_en), 32'd0);
        chk("sh_mis_err", 32'(r_err), 32'd1);
        chk("sh_mis_rdata", r_rd, 32'd0);
        txn(0, 0, 0, 3'b001, 12'h012, 32'h0);
        chk("lw_mis_en", 32'(r_en), 32'd0);
        chk("lw_mis_err", 32'(r_err), 32'd1);
        chk("lw_mis_rdata", r_rd, 32'd0);
        txn(0, 0, 0, 3'b011, 12'h010, 32'h0);
        chk("size_bad_err", 32'(r_err), 32'd1);
        chk("size_bad_en", 32'(r_en), 32'd0);
        txn(0, 0, 0, 3'b001, 12'h010, 32'h0);
        chk("mis_no_write", r_rd, 32'h1234BEEF);

        // debug port
        txn(0, 1, 0, 3'b001, 12'h010, 32'h12345678);
        txn(1, 0, 0, 3'b001, 12'h013, 32'h0);
        chk("dbg_rd_addr", 32'(r_ma), 32'h004);
        chk("dbg_rd_be", 32'(r_be), 32'hF);
        chk("dbg_rdata", r_rd, 32'h12345678);
        txn(1, 1, 0, 3'b001, 12'h022, 32'hCAFEF00D);
        chk("dbg_wr_addr", 32'(r_ma), 32'h008);
        chk("dbg_wr_rdata", r_rd, 32'd0);
        txn(0, 0, 0, 3'b001, 12'h020, 32'h0);
        chk("core_rd_dbg_wr", r_rd, 32'hCAFEF00D);

        // starvation: both held high
        core_we = 0; core_uns = 0; core_size = 3'b001; core_addr = 12'h010; dbg_we = 0;
        core_req = 1; dbg_req = 1;
        grab(10);
        core_req = 0; dbg_req = 0;
        chk("starve_order", 32'(r_seq), 32'(10'b0000100001));
        repeat (3) @(negedge clk);

        // reset during ISSUE with counter built up
        core_req = 1; dbg_req = 1;
        grab(4);
        chk("pre_rst_order", 32'(r_seq), 32'd0);
        rst = 1; core_req = 0; dbg_req = 0;
        @(negedge clk);
        chk("rst_issue_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_issue_en", 32'(mem_en | core_gnt), 32'd0);
        rst = 0;
        @(negedge clk);
        chk("rst_issue_rvalid2", 32'(core_rvalid | dbg_rvalid), 32'd0);
        core_req = 1; dbg_req = 1;
        grab(5);
        core_req = 0; dbg_req = 0;
        chk("post_rst_order", 32'(r_seq), 32'(10'b0000000001));
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
